// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, sequencer state encoding and instruction field positions
package proc_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_I,
    LATCH_I,
    LATCH_IMM,
    ISSUE,
    IMM,
    WAIT_DONE,
    HALT,
    ERRO
  } seq_state_e;

endpackage

// File: rtl/contador_programa.sv
// rtl/contador_programa.sv - program counter with clear and +1/+2 steps
module contador_programa #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              inc1_i,
  input  logic              inc2_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Clear wins over the increments; +2 skips the mvi immediate word.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (inc2_i) begin
      pc_d = pc_q + ADDR_W'(2);
    end else if (inc1_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/sequenciador_programa.sv
// rtl/sequenciador_programa.sv - feeds ROM instructions to the processor DIN/Run/Done handshake
module sequenciador_programa
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] addr_fim,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       proc_DIN,
  output logic              proc_Run,
  input  logic              proc_Done,
  output logic              Busy,
  output logic              Halted,
  output logic              erro,
  output logic [15:0]       instr_count
);

  localparam int WD_W = $clog2(TIMEOUT + 2);

  seq_state_e          state_q;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_plus1;
  logic [ADDR_W-1:0]   fim_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [INSTR_W-1:0]  imm_q;
  logic [INSTR_W-1:0]  din_q;
  logic [15:0]         count_q;
  logic [WD_W-1:0]     wd_q;
  logic                run_q;
  logic                busy_q;
  logic                halted_q;
  logic                erro_q;

  logic start_ok;
  logic fetch_mvi;
  logic instr_mvi;
  logic done_ok;
  logic at_end;
  logic wd_expired;
  logic pc_inc1;
  logic pc_inc2;

  assign start_ok   = Start && (state_q inside {IDLE, HALT, ERRO});
  assign fetch_mvi  = mem_data[OPC_MSB:OPC_LSB] == OP_MVI;
  assign instr_mvi  = instr_q[OPC_MSB:OPC_LSB] == OP_MVI;
  assign pc_plus1   = pc + ADDR_W'(1);
  assign done_ok    = (state_q inside {IMM, WAIT_DONE}) && proc_Done;
  // The immediate address counts as part of the mvi for the end-of-program test.
  assign at_end     = (pc == fim_q) || (instr_mvi && (pc_plus1 == fim_q));
  assign wd_expired = (wd_q + WD_W'(1)) == WD_W'(TIMEOUT);
  assign pc_inc1    = done_ok && !at_end && !instr_mvi;
  assign pc_inc2    = done_ok && !at_end && instr_mvi;

  contador_programa #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk_i   (Clock),
    .rst_n_i (Resetn),
    .clr_i   (start_ok),
    .inc1_i  (pc_inc1),
    .inc2_i  (pc_inc2),
    .pc_o    (pc)
  );

  // The ROM is synchronous, so the address must be combinational to keep the fetch cadence.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      FETCH_I: mem_addr = pc;
      LATCH_I: mem_addr = fetch_mvi ? pc_plus1 : pc;
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      fim_q    <= '0;
      instr_q  <= '0;
      imm_q    <= '0;
      din_q    <= '0;
      count_q  <= '0;
      wd_q     <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      run_q <= 1'b0;
      din_q <= '0;
      case (state_q)
        IDLE, HALT, ERRO: begin
          if (Start) begin
            count_q  <= '0;
            fim_q    <= addr_fim;
            state_q  <= FETCH_I;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            erro_q   <= 1'b0;
          end
        end
        FETCH_I: state_q <= LATCH_I;
        LATCH_I: begin
          instr_q <= mem_data;
          if (fetch_mvi) begin
            state_q <= LATCH_IMM;
          end else begin
            state_q <= ISSUE;
            run_q   <= 1'b1;
            din_q   <= mem_data;
          end
        end
        LATCH_IMM: begin
          imm_q   <= mem_data;
          state_q <= ISSUE;
          run_q   <= 1'b1;
          din_q   <= instr_q;
        end
        ISSUE: begin
          wd_q <= '0;
          if (instr_mvi) begin
            state_q <= IMM;
            din_q   <= imm_q;
          end else begin
            state_q <= WAIT_DONE;
          end
        end
        IMM, WAIT_DONE: begin
          if (proc_Done) begin
            count_q <= count_q + 16'd1;
            if (at_end) begin
              state_q  <= HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH_I;
            end
          end else if (wd_expired) begin
            state_q <= ERRO;
            busy_q  <= 1'b0;
            erro_q  <= 1'b1;
          end else begin
            wd_q    <= wd_q + WD_W'(1);
            state_q <= WAIT_DONE;
            din_q   <= instr_mvi ? imm_q : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign proc_DIN    = din_q;
  assign proc_Run    = run_q;
  assign Busy        = busy_q;
  assign Halted      = halted_q;
  assign erro        = erro_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// tb/tb_sequenciador_programa.sv - directed vector bench with a ROM and a small processor model
module tb_sequenciador_programa;
  import proc_pkg::*;

  localparam int AW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] addr_fim;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [15:0]   proc_din;
  logic          proc_run;
  logic          proc_done;
  logic          busy;
  logic          halted;
  logic          erro;
  logic [15:0]   instr_count;

  sequenciador_programa #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .Clock       (clk),
    .Resetn      (rst_n),
    .Start       (start),
    .addr_fim    (addr_fim),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .proc_DIN    (proc_din),
    .proc_Run    (proc_run),
    .proc_Done   (proc_done),
    .Busy        (busy),
    .Halted      (halted),
    .erro        (erro),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  logic [15:0] rom [16];
  always @(posedge clk) mem_data <= rom[mem_addr];
  always @(posedge clk) ecnt++;

  // processor model state
  logic [15:0] R [8];
  logic [15:0] cur, imm;
  logic [AW-1:0] exp_pc, imm_a;
  int lat, len, run_e, done_e, start_e, runs, dones, k;
  bit never, pending, first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {7'd0, op, rx, ry};
  endfunction

  always @(negedge rst_n) begin
    pending = 0;
    proc_done = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      proc_done = 1'b0;
      if (proc_run) begin
        chk("run_din", 32'(proc_din), 32'(rom[exp_pc]));
        if (first) chk("first_run_latency", 32'(ecnt - start_e), (rom[exp_pc][8:6] == OP_MVI) ? 32'd3 : 32'd2);
        else chk("run_gap", 32'(ecnt - done_e), (rom[exp_pc][8:6] == OP_MVI) ? 32'd4 : 32'd3);
        first = 0;
        cur = rom[exp_pc];
        run_e = ecnt;
        pending = 1;
        runs++;
      end
      if (pending) begin
        k = ecnt - run_e;
        if (k == 1 && cur[8:6] == OP_MVI) begin
          imm_a = exp_pc + 4'd1;
          imm = rom[imm_a];
          chk("imm_din", 32'(proc_din), 32'(imm));
        end
        if (!never && k >= lat && k < lat + len) proc_done = 1'b1;
        if (proc_done && k >= 1) begin
          case (cur[8:6])
            OP_MV:   R[cur[5:3]] = R[cur[2:0]];
            OP_MVI:  R[cur[5:3]] = imm;
            OP_ADD:  R[cur[5:3]] = R[cur[5:3]] + R[cur[2:0]];
            default: R[cur[5:3]] = R[cur[5:3]] - R[cur[2:0]];
          endcase
          done_e = ecnt;
          dones++;
          exp_pc = exp_pc + ((cur[8:6] == OP_MVI) ? 4'd2 : 4'd1);
          pending = 0;
        end
      end
    end
  end

  task automatic init_proc();
    for (int i = 0; i < 8; i++) R[i] = 16'(i * 16'h11);
    runs = 0;
    dones = 0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 16; a++) rom[a] = 16'h0000;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    start_e = ecnt + 1;
    first = 1;
    exp_pc = '0;
    @(negedge clk);
    #1;
    chk("start_fetch_addr", 32'(mem_addr), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (halted || erro) break;
    end
    if (n == 400) chk({name, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_run(input int target);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      #1;
      if (runs >= target) break;
    end
    if (n == 60) chk("wait_run_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0][15:0] prog;
    logic [AW-1:0]    fim;
    int               lat;
    int               exp_count;
    logic [15:0]      exp_r1;
  } vec_t;

  vec_t vecs [6];
  int re;

  initial begin
    vecs[0].prog = '0; vecs[0].prog[0] = enc(OP_MVI, 3'd0, 3'd0); vecs[0].prog[1] = 16'h0005;
    vecs[0].prog[2] = enc(OP_MV, 3'd1, 3'd0); vecs[0].fim = 4'd2; vecs[0].lat = 2;
    vecs[0].exp_count = 2; vecs[0].exp_r1 = 16'h0005;
    vecs[1].prog = '0; vecs[1].prog[0] = enc(OP_ADD, 3'd1, 3'd2); vecs[1].fim = 4'd0; vecs[1].lat = 2;
    vecs[1].exp_count = 1; vecs[1].exp_r1 = 16'h0033;
    vecs[2].prog = '0; vecs[2].prog[0] = enc(OP_MV, 3'd1, 3'd4); vecs[2].fim = 4'd0; vecs[2].lat = 3;
    vecs[2].exp_count = 1; vecs[2].exp_r1 = 16'h0044;
    vecs[3].prog = '0; vecs[3].prog[0] = enc(OP_SUB, 3'd1, 3'd2); vecs[3].prog[1] = enc(OP_ADD, 3'd1, 3'd3);
    vecs[3].fim = 4'd1; vecs[3].lat = 1; vecs[3].exp_count = 2; vecs[3].exp_r1 = 16'h0022;
    vecs[4].prog = '0; vecs[4].prog[0] = enc(OP_MVI, 3'd1, 3'd0); vecs[4].prog[1] = 16'h1234;
    vecs[4].prog[2] = enc(OP_ADD, 3'd1, 3'd1); vecs[4].fim = 4'd2; vecs[4].lat = 1;
    vecs[4].exp_count = 2; vecs[4].exp_r1 = 16'h2468;
    vecs[5].prog = '0; vecs[5].prog[0] = enc(OP_MV, 3'd2, 3'd3); vecs[5].prog[1] = enc(OP_MVI, 3'd1, 3'd0);
    vecs[5].prog[2] = 16'h0007; vecs[5].fim = 4'd2; vecs[5].lat = 2;
    vecs[5].exp_count = 2; vecs[5].exp_r1 = 16'h0007;

    rst_n = 1'b0; start = 1'b0; addr_fim = '0; proc_done = 1'b0;
    never = 0; lat = 2; len = 1; pending = 0; first = 0; exp_pc = '0;
    clear_rom();
    init_proc();
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, halted, erro, proc_run, 12'd0, proc_din}, 32'd0);
    chk("reset_count_addr", {12'd0, mem_addr, instr_count}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      clear_rom();
      for (int a = 0; a < 4; a++) rom[a] = vecs[i].prog[a];
      addr_fim = vecs[i].fim; lat = vecs[i].lat; len = 1; never = 0;
      init_proc();
      do_start();
      wait_end("vec");
      chk("vec_halted", 32'(halted), 32'd1);
      chk("vec_erro", 32'(erro), 32'd0);
      chk("vec_busy", 32'(busy), 32'd0);
      chk("vec_count", 32'(instr_count), 32'(vecs[i].exp_count));
      chk("vec_runs", 32'(runs), 32'(vecs[i].exp_count));
      chk("vec_r1", 32'(R[1]), 32'(vecs[i].exp_r1));
    end

    // mvi at the last address takes its immediate from the wrapped address 0
    clear_rom();
    rom[0] = 16'h00AB;
    rom[15] = enc(OP_MVI, 3'd1, 3'd0);
    addr_fim = 4'd15; lat = 1; len = 1; never = 0;
    init_proc();
    do_start();
    wait_end("wrap");
    chk("wrap_halted", 32'(halted), 32'd1);
    chk("wrap_count", 32'(instr_count), 32'd16);
    chk("wrap_r1", 32'(R[1]), 32'h00AB);

    // watchdog expiry, then restart
    clear_rom();
    rom[0] = enc(OP_ADD, 3'd1, 3'd2);
    addr_fim = 4'd5; never = 1;
    init_proc();
    do_start();
    wait_end("timeout");
    chk("to_erro", 32'(erro), 32'd1);
    chk("to_latency", 32'(ecnt - run_e), 32'(TO + 1));
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_halted", 32'(halted), 32'd0);
    chk("to_count", 32'(instr_count), 32'd0);
    never = 0; lat = 2; addr_fim = 4'd0;
    init_proc();
    do_start();
    chk("restart_erro_clear", 32'(erro), 32'd0);
    wait_end("restart");
    chk("restart_halted", 32'(halted), 32'd1);
    chk("restart_count", 32'(instr_count), 32'd1);

    // Done asserted together with Run and held for one more cycle
    clear_rom();
    rom[0] = enc(OP_ADD, 3'd1, 3'd2);
    addr_fim = 4'd0; lat = 0; len = 2; never = 0;
    init_proc();
    do_start();
    wait_run(1);
    re = ecnt;
    @(negedge clk); #1;
    chk("hold_ignored_count", 32'(instr_count), 32'd0);
    chk("hold_ignored_halt", 32'(halted), 32'd0);
    @(negedge clk); #1;
    chk("hold_cycle", 32'(ecnt - re), 32'd2);
    chk("hold_count", 32'(instr_count), 32'd1);
    chk("hold_halted", 32'(halted), 32'd1);
    chk("hold_r1", 32'(R[1]), 32'h0033);

    // reset while waiting for Done
    clear_rom();
    rom[1] = enc(OP_ADD, 3'd1, 3'd2);
    addr_fim = 4'd1; lat = 2; len = 1; never = 0;
    init_proc();
    do_start();
    for (int n = 0; n < 60 && dones < 1; n++) begin
      @(negedge clk); #1;
    end
    never = 1;
    wait_run(2);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_count", 32'(instr_count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {busy, halted, erro, proc_run, 12'd0, proc_din}, 32'd0);
    chk("async_reset_count", {12'd0, mem_addr, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    never = 0; addr_fim = 4'd0;
    init_proc();
    do_start();
    wait_end("post_reset");
    chk("post_reset_halted", 32'(halted), 32'd1);
    chk("post_reset_count", 32'(instr_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
